counter_sequencer: RTL and testbench

Sequencing controller for the design's 4-bit counter datapath. It loads a start value, steps the counter up or down (modulo 16) toward a programmed end value, and then either finishes with a done pulse or reloads and repeats. It sits between the top-level I/O decode and the `uo_out[3:0]` counter output, and adds pause and abort control plus a pass counter.

---
 rtl/counter_sequencer.sv | 167 ++++++++++++++++
 tb/tb_counter_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: sequencing controller for the 4-bit counter datapath.
// Loads a start value, steps the counter up or down (modulo 16) toward a
// programmed end value, then finishes with a done pulse or reloads and repeats.
// Adds pause/abort control and a saturating pass counter.
// Optional feature: define CTR_SEQ_PRESCALE_EN to add a tick prescaler.
module counter_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] start_val,
    input  logic [3:0] end_val,
    input  logic       dir,
    input  logic       repeat_en,
    input  logic       pause,
    input  logic       abort,
    input  logic [3:0] prescale,
    output logic [3:0] count,
    output logic       busy,
    output logic       done,
    output logic [3:0] passes
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] passes_q, passes_d;
    logic [3:0] start_q, start_d;
    logic [3:0] end_q, end_d;
    logic       dir_q, dir_d;
    logic       rep_q, rep_d;
    logic       tick;
    logic       accept;

    // A start is accepted only in IDLE and only when no abort is present.
    assign accept = (state_q == ST_IDLE) && start && !abort;

`ifdef CTR_SEQ_PRESCALE_EN
    logic [3:0] prescale_q, prescale_d;
    logic [3:0] pre_cnt_q, pre_cnt_d;

    assign tick = (pre_cnt_q == prescale_q);

    // Prescaler: cleared on start and on each tick, frozen while paused.
    always_comb begin
        pre_cnt_d  = pre_cnt_q;
        prescale_d = prescale_q;
        if (accept) begin
            pre_cnt_d  = 4'd0;
            prescale_d = prescale;
        end else if ((state_q == ST_RUN) && !abort && !pause) begin
            pre_cnt_d = tick ? 4'd0 : pre_cnt_q + 4'd1;
        end
    end

    // Prescaler registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q  <= 4'd0;
            prescale_q <= 4'd0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            prescale_q <= prescale_d;
        end
    end
`else
    logic unused_prescale;

    assign tick            = 1'b1;
    assign unused_prescale = ^prescale;
`endif

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        passes_d = passes_q;
        start_d  = start_q;
        end_d    = end_q;
        dir_d    = dir_q;
        rep_d    = rep_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    start_d  = start_val;
                    end_d    = end_val;
                    dir_d    = dir;
                    rep_d    = repeat_en;
                    count_d  = start_val;
                    passes_d = 4'd0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (!pause && tick) begin
                    if (count_q == end_q) begin
                        done_d = 1'b1;
                        if (passes_q != 4'd15) begin
                            passes_d = passes_q + 4'd1;
                        end
                        if (rep_q) begin
                            count_d = start_q;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_DONE;
                        end
                    end else if (dir_q) begin
                        count_d = count_q - 4'd1;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, outputs and latched configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            passes_q <= 4'd0;
            start_q  <= 4'd0;
            end_q    <= 4'd0;
            dir_q    <= 1'b0;
            rep_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            passes_q <= passes_d;
            start_q  <= start_d;
            end_q    <= end_d;
            dir_q    <= dir_d;
            rep_q    <= rep_d;
        end
    end

    assign count  = count_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign passes = passes_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer: directed scenarios plus randomized
// stimulus, compared every cycle against a behavioural sequence model.
module tb_counter_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] start_val;
    logic [3:0] end_val;
    logic       dir;
    logic       repeat_en;
    logic       pause;
    logic       abort;
    logic [3:0] prescale;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [3:0] passes;

    int checkCount;
    int passCount;
    int failCount;

    // Behavioural model: a sequence is "running", "finishing" (one cycle of
    // done after a one-shot), or neither (idle).
    bit       mRunning;
    bit       mFinishing;
    int       mCount;
    int       mPasses;
    bit       mDone;
    int       mStart;
    int       mEnd;
    bit       mDown;
    bit       mRepeat;
    int       mHoldLen;
    int       mHeld;

    counter_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_val (start_val),
        .end_val   (end_val),
        .dir       (dir),
        .repeat_en (repeat_en),
        .pause     (pause),
        .abort     (abort),
        .prescale  (prescale),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .passes    (passes)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mRunning   = 1'b0;
        mFinishing = 1'b0;
        mCount     = 0;
        mPasses    = 0;
        mDone      = 1'b0;
        mStart     = 0;
        mEnd       = 0;
        mDown      = 1'b0;
        mRepeat    = 1'b0;
        mHoldLen   = 1;
        mHeld      = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic modelStep();
        mDone = 1'b0;
        if (mFinishing) begin
            mFinishing = 1'b0;
        end else if (!mRunning) begin
            if (start && !abort) begin
                mStart   = int'(start_val);
                mEnd     = int'(end_val);
                mDown    = dir;
                mRepeat  = repeat_en;
`ifdef CTR_SEQ_PRESCALE_EN
                mHoldLen = int'(prescale) + 1;
`else
                mHoldLen = 1;
`endif
                mHeld    = 0;
                mCount   = mStart;
                mPasses  = 0;
                mRunning = 1'b1;
            end
        end else if (abort) begin
            mRunning = 1'b0;
        end else if (!pause) begin
            mHeld++;
            if (mHeld == mHoldLen) begin
                mHeld = 0;
                if (mCount == mEnd) begin
                    mDone   = 1'b1;
                    mPasses = (mPasses < 15) ? mPasses + 1 : 15;
                    if (mRepeat) begin
                        mCount = mStart;
                    end else begin
                        mRunning   = 1'b0;
                        mFinishing = 1'b1;
                    end
                end else begin
                    mCount = (mCount + (mDown ? 15 : 1)) % 16;
                end
            end
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".count"},  int'(count),  mCount);
        checkOutput({tag, ".busy"},   int'(busy),   int'(mRunning));
        checkOutput({tag, ".done"},   int'(done),   int'(mDone));
        checkOutput({tag, ".passes"}, int'(passes), mPasses);
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic applyStimulus(input bit st, input logic [3:0] sv, input logic [3:0] ev,
                                 input bit d, input bit rp, input bit ps, input bit ab,
                                 input logic [3:0] pre, input string tag);
        start     = st;
        start_val = sv;
        end_val   = ev;
        dir       = d;
        repeat_en = rp;
        pause     = ps;
        abort     = ab;
        prescale  = pre;
        @(posedge clk);
        #1;
        modelStep();
        checkModel(tag);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        modelReset();
        rst = 1'b1;
        start = 1'b0; start_val = 4'd0; end_val = 4'd0; dir = 1'b0;
        repeat_en = 1'b0; pause = 1'b0; abort = 1'b0; prescale = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.count",  int'(count),  0);
        checkOutput("reset.busy",   int'(busy),   0);
        checkOutput("reset.done",   int'(done),   0);
        checkOutput("reset.passes", int'(passes), 0);
        rst = 1'b0;

        // Up count 2..5 one-shot, start held high to show it is ignored while busy.
        applyStimulus(1, 4'd2, 4'd5, 0, 0, 0, 0, 4'd0, "up.start");
        checkOutput("up.first", int'(count), 2);
        for (int i = 3; i <= 5; i++) begin
            applyStimulus(1, 4'd9, 4'd9, 1, 0, 0, 0, 4'd0, "up.step");
            checkOutput("up.value", int'(count), i);
        end
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, "up.end");
        checkOutput("up.done", int'(done), 1);
        checkOutput("up.busy", int'(busy), 0);
        checkOutput("up.hold", int'(count), 5);
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, "up.after");
        checkOutput("up.donefall", int'(done), 0);

        // Down count with wrap 1..14.
        applyStimulus(1, 4'd1, 4'd14, 1, 0, 0, 0, 4'd0, "down.start");
        repeat (3) applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, "down.step");
        checkOutput("down.wrap", int'(count), 14);
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, "down.end");
        checkOutput("down.done",   int'(done),   1);
        checkOutput("down.passes", int'(passes), 1);
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, "down.idle");

        // Repeat 0..2 for three passes, then abort at count 1.
        applyStimulus(1, 4'd0, 4'd2, 0, 1, 0, 0, 4'd0, "rep.start");
        repeat (9) applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, "rep.run");
        checkOutput("rep.passes", int'(passes), 3);
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, "rep.step");
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd0, "rep.abort");
        checkOutput("rep.abortcount", int'(count), 1);
        checkOutput("rep.abortbusy",  int'(busy),  0);
        checkOutput("rep.abortdone",  int'(done),  0);

        // Pause for four cycles at count 4, then resume to 5.
        applyStimulus(1, 4'd3, 4'd8, 0, 0, 0, 0, 4'd0, "pause.start");
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, "pause.step");
        repeat (4) begin
            applyStimulus(0, 4'd0, 4'd0, 0, 0, 1, 0, 4'd0, "pause.hold");
            checkOutput("pause.frozen", int'(count), 4);
        end
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, "pause.resume");
        checkOutput("pause.next", int'(count), 5);

        // Asynchronous reset mid-run at count 5: outputs clear before the next edge.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst.count",  int'(count),  0);
        checkOutput("arst.busy",   int'(busy),   0);
        checkOutput("arst.done",   int'(done),   0);
        checkOutput("arst.passes", int'(passes), 0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, "arst.idle");

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom_range(0, 3) == 0),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0),
                          4'($urandom_range(0, 3)), "rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
